// File: rtl/ov7670_sccb_sched.sv
// OV7670 SCCB scheduler: shares one SCCB master between the power-up init table and host commands.
// Build option OV7670_INIT_ROM_EN adds the init table and PWRUP/INIT states; without it reset lands in IDLE.
module ov7670_sccb_sched #(
  parameter logic [19:0] P_PWRUP_WAIT = 20'd40000,
  parameter logic [19:0] P_SWRST_WAIT = 20'd40000,
  parameter logic [15:0] P_TIMEOUT    = 16'd50000,
  parameter logic [3:0]  P_INIT_LEN   = 4'd8
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       HOST_WR,
  input  logic       HOST_RD,
  input  logic [7:0] HOST_ADR,
  input  logic [7:0] HOST_DATA,
  output logic       HOST_DROP,
  output logic       SCCB_REQ,
  output logic       SCCB_RW,
  output logic [7:0] SCCB_ADR,
  output logic [7:0] SCCB_WDATA,
  input  logic       SCCB_BUSY,
  input  logic       SCCB_DONE,
  input  logic       SCCB_ACK_ERR,
  input  logic [7:0] SCCB_RDATA,
  output logic [7:0] RD_DATA,
  output logic       RD_VALID,
  output logic       INIT_DONE,
  output logic       ERR_FLAG
);

  typedef enum logic [2:0] {
    S_PWRUP, S_INIT_ISSUE, S_INIT_WAIT, S_INIT_DELAY,
    S_IDLE, S_HOST_ISSUE, S_HOST_WAIT, S_HOST_DELAY
  } state_t;

`ifdef OV7670_INIT_ROM_EN
  localparam state_t S_RST = S_PWRUP;

  function automatic logic [15:0] init_entry(input logic [3:0] i);
    case (i)
      4'd0:    init_entry = 16'h1280;
      4'd1:    init_entry = 16'h1101;
      4'd2:    init_entry = 16'h1204;
      4'd3:    init_entry = 16'h40D0;
      4'd4:    init_entry = 16'h8C00;
      4'd5:    init_entry = 16'h3A04;
      4'd6:    init_entry = 16'h0C00;
      4'd7:    init_entry = 16'h3E00;
      default: init_entry = 16'h0000;
    endcase
  endfunction

  logic [3:0] idx;  // number of table entries already loaded
`else
  localparam state_t S_RST = S_IDLE;
  logic unused_params;
  assign unused_params = ^{P_PWRUP_WAIT, P_INIT_LEN};
`endif

  state_t      state, state_nx;
  logic [19:0] wcnt;
  logic [15:0] tcnt;
  logic        slot_v, slot_rw;
  logic [7:0]  slot_adr, slot_data;
  logic        in_wait, tmo, fin, swrst, slot_free, ld;
  logic [16:0] ld_cmd;

  assign SCCB_REQ  = (state == S_INIT_ISSUE || state == S_HOST_ISSUE) && !SCCB_BUSY;
  assign slot_free = SCCB_REQ && state == S_HOST_ISSUE;
  assign in_wait   = state == S_INIT_WAIT || state == S_HOST_WAIT;
  assign tmo       = in_wait && !SCCB_DONE && tcnt == P_TIMEOUT;
  assign fin       = in_wait && (SCCB_DONE || tmo);
  // sensor soft reset: COM7 (0x12) write with bit7 set needs settling time
  assign swrst     = !SCCB_RW && SCCB_ADR == 8'h12 && SCCB_WDATA[7];

  always_comb begin
    state_nx = state;
    ld       = 1'b0;
    ld_cmd   = '0;
    case (state)
`ifdef OV7670_INIT_ROM_EN
      S_PWRUP:
        if (wcnt == P_PWRUP_WAIT - 20'd1) begin
          state_nx = S_INIT_ISSUE; ld = 1'b1; ld_cmd = {1'b0, init_entry(idx)};
        end
      S_INIT_ISSUE: if (SCCB_REQ) state_nx = S_INIT_WAIT;
      S_INIT_WAIT:
        if (fin) begin
          if (swrst) state_nx = S_INIT_DELAY;
          else if (idx == P_INIT_LEN) state_nx = S_IDLE;
          else begin
            state_nx = S_INIT_ISSUE; ld = 1'b1; ld_cmd = {1'b0, init_entry(idx)};
          end
        end
      S_INIT_DELAY:
        if (wcnt == P_SWRST_WAIT - 20'd1) begin
          if (idx == P_INIT_LEN) state_nx = S_IDLE;
          else begin
            state_nx = S_INIT_ISSUE; ld = 1'b1; ld_cmd = {1'b0, init_entry(idx)};
          end
        end
`endif
      S_IDLE:
        if (slot_v && INIT_DONE) begin
          state_nx = S_HOST_ISSUE; ld = 1'b1; ld_cmd = {slot_rw, slot_adr, slot_data};
        end
      S_HOST_ISSUE: if (SCCB_REQ) state_nx = S_HOST_WAIT;
      S_HOST_WAIT:  if (fin) state_nx = swrst ? S_HOST_DELAY : S_IDLE;
      S_HOST_DELAY: if (wcnt == P_SWRST_WAIT - 20'd1) state_nx = S_IDLE;
      default:      state_nx = S_RST;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= S_RST;
      wcnt       <= '0;
      tcnt       <= '0;
      slot_v     <= 1'b0;
      slot_rw    <= 1'b0;
      slot_adr   <= '0;
      slot_data  <= '0;
      SCCB_RW    <= 1'b0;
      SCCB_ADR   <= '0;
      SCCB_WDATA <= '0;
      HOST_DROP  <= 1'b0;
      RD_DATA    <= '0;
      RD_VALID   <= 1'b0;
      INIT_DONE  <= 1'b0;
      ERR_FLAG   <= 1'b0;
    end else begin
      state <= state_nx;
      wcnt  <= (state_nx != state) ? 20'd0 : wcnt + 20'd1;
      if (SCCB_REQ)     tcnt <= 16'd1;
      else if (in_wait) tcnt <= tcnt + 16'd1;
      if (ld) {SCCB_RW, SCCB_ADR, SCCB_WDATA} <= ld_cmd;

      // one-entry slot; WR has priority over a simultaneous RD
      HOST_DROP <= 1'b0;
      if ((HOST_WR || HOST_RD) && (!slot_v || slot_free)) begin
        slot_v    <= 1'b1;
        slot_rw   <= !HOST_WR;
        slot_adr  <= HOST_ADR;
        slot_data <= HOST_DATA;
      end else if (slot_free) begin
        slot_v <= 1'b0;
      end else if (HOST_WR || HOST_RD) begin
        HOST_DROP <= 1'b1;
      end

      RD_VALID <= 1'b0;
      if (fin) begin
        if (tmo || SCCB_ACK_ERR) ERR_FLAG <= 1'b1;
        if (state == S_HOST_WAIT && SCCB_RW && SCCB_DONE && !SCCB_ACK_ERR) begin
          RD_DATA  <= SCCB_RDATA;
          RD_VALID <= 1'b1;
        end
      end
      if (state_nx == S_IDLE) INIT_DONE <= 1'b1;
    end
  end

`ifdef OV7670_INIT_ROM_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)                              idx <= '0;
    else if (ld && state_nx == S_INIT_ISSUE) idx <= idx + 4'd1;
  end
`endif

endmodule

// File: tb/tb_ov7670_sccb_sched.sv
// Directed bench for ov7670_sccb_sched with a simple SCCB slave model (DONE ~10 cycles after REQ).
module tb_ov7670_sccb_sched;
  localparam int SWRST = 20;
  localparam int TMO   = 40;

  logic       CLK = 1'b0, RESET = 1'b1;
  logic       HOST_WR = 1'b0, HOST_RD = 1'b0;
  logic [7:0] HOST_ADR = '0, HOST_DATA = '0;
  logic       HOST_DROP, SCCB_REQ, SCCB_RW;
  logic [7:0] SCCB_ADR, SCCB_WDATA, RD_DATA;
  logic       SCCB_BUSY = 1'b0, SCCB_DONE = 1'b0, SCCB_ACK_ERR = 1'b0;
  logic [7:0] SCCB_RDATA = '0;
  logic       RD_VALID, INIT_DONE, ERR_FLAG;

  int checks = 0, errors = 0;
  int nreq = 0, cyc = 0, dly = 0, pend_idx = 0;
  int nack_at = -1;
  bit hang = 1'b0;
  logic [7:0] log_adr [64];
  logic [7:0] log_dat [64];
  logic       log_rw  [64];
  int         log_cyc [64];

  ov7670_sccb_sched #(
    .P_PWRUP_WAIT(20'd30), .P_SWRST_WAIT(20'd20), .P_TIMEOUT(16'd40), .P_INIT_LEN(4'd8)
  ) dut (
    .CLK(CLK), .RESET(RESET), .HOST_WR(HOST_WR), .HOST_RD(HOST_RD),
    .HOST_ADR(HOST_ADR), .HOST_DATA(HOST_DATA), .HOST_DROP(HOST_DROP),
    .SCCB_REQ(SCCB_REQ), .SCCB_RW(SCCB_RW), .SCCB_ADR(SCCB_ADR), .SCCB_WDATA(SCCB_WDATA),
    .SCCB_BUSY(SCCB_BUSY), .SCCB_DONE(SCCB_DONE), .SCCB_ACK_ERR(SCCB_ACK_ERR),
    .SCCB_RDATA(SCCB_RDATA), .RD_DATA(RD_DATA), .RD_VALID(RD_VALID),
    .INIT_DONE(INIT_DONE), .ERR_FLAG(ERR_FLAG)
  );

  always #5 CLK = ~CLK;

  // slave model: logs every request, answers with DONE unless hang is set
  always @(posedge CLK) begin
    cyc          <= cyc + 1;
    SCCB_DONE    <= 1'b0;
    SCCB_ACK_ERR <= 1'b0;
    if (RESET) begin
      dly <= 0;
    end else if (SCCB_REQ) begin
      if (nreq < 64) begin
        log_adr[nreq] <= SCCB_ADR;
        log_dat[nreq] <= SCCB_WDATA;
        log_rw[nreq]  <= SCCB_RW;
        log_cyc[nreq] <= cyc;
      end
      pend_idx <= nreq;
      nreq     <= nreq + 1;
      dly      <= hang ? 0 : 10;
    end else if (dly != 0) begin
      dly <= dly - 1;
      if (dly == 1) begin
        SCCB_DONE    <= 1'b1;
        SCCB_ACK_ERR <= (pend_idx == nack_at);
        SCCB_RDATA   <= 8'h76;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge CLK);
  endtask

  task automatic host(input logic wr, input logic rd, input logic [7:0] adr, input logic [7:0] dat);
    HOST_WR = wr; HOST_RD = rd; HOST_ADR = adr; HOST_DATA = dat;
    @(negedge CLK);
    HOST_WR = 1'b0; HOST_RD = 1'b0;
  endtask

  task automatic wait_req(input int target, input int budget, input string tag);
    int n = 0;
    while (nreq < target && n < budget) begin @(negedge CLK); n++; end
    chk(tag, 32'(nreq >= target), 32'd1);
  endtask

  task automatic wait_rdv(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge CLK);
      if (RD_VALID) seen = 1'b1;
    end
  endtask

  initial begin
    bit seen;
    int b, n;
    logic [15:0] tbl [8];
    tbl = '{16'h1280, 16'h1101, 16'h1204, 16'h40D0, 16'h8C00, 16'h3A04, 16'h0C00, 16'h3E00};

    cycles(3);
    chk("rst_req",   32'(SCCB_REQ), 32'd0);
    chk("rst_drop",  32'(HOST_DROP), 32'd0);
    chk("rst_rdv",   32'(RD_VALID), 32'd0);
    chk("rst_idone", 32'(INIT_DONE), 32'd0);
    chk("rst_err",   32'(ERR_FLAG), 32'd0);
    chk("rst_adr",   32'({SCCB_RW, SCCB_ADR, SCCB_WDATA}), 32'd0);
    chk("rst_rdata", 32'(RD_DATA), 32'd0);

`ifdef OV7670_INIT_ROM_EN
    nack_at = 3;
    RESET = 1'b0;
    cycles(3);
    host(1'b1, 1'b0, 8'h3A, 8'h04);
    chk("init_cap_nodrop", 32'(HOST_DROP), 32'd0);
    host(1'b1, 1'b0, 8'h55, 8'hAA);
    chk("init_drop", 32'(HOST_DROP), 32'd1);
    @(negedge CLK);
    chk("init_drop_pulse", 32'(HOST_DROP), 32'd0);
    wait_req(8, 500, "init_8req");
    chk("idone_before_last", 32'(INIT_DONE), 32'd0);
    for (int i = 0; i < 8; i++) chk($sformatf("init_tbl%0d", i), 32'({log_rw[i], log_adr[i], log_dat[i]}), 32'(tbl[i]));
    chk("swrst_gap",   32'(log_cyc[1] - log_cyc[0] >= SWRST + 10), 32'd1);
    chk("noswrst_gap", 32'(log_cyc[3] - log_cyc[2] < SWRST + 10), 32'd1);
    wait_req(9, 100, "held_host_req");
    chk("idone_after", 32'(INIT_DONE), 32'd1);
    chk("held_cmd",    32'({log_rw[8], log_adr[8], log_dat[8]}), 32'h03A04);
    chk("nack_err",    32'(ERR_FLAG), 32'd1);
    nack_at = -1;
    cycles(15);
    // reset in the middle of an init transfer
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    b = nreq;
    wait_req(b + 1, 80, "rst2_first_req");
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    chk("midrst_req",   32'(SCCB_REQ), 32'd0);
    chk("midrst_idone", 32'(INIT_DONE), 32'd0);
    chk("midrst_err",   32'(ERR_FLAG), 32'd0);
    chk("midrst_adr",   32'(SCCB_ADR), 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    wait_req(b + 2, 80, "restart_req");
    chk("restart_entry0", 32'({log_rw[b+1], log_adr[b+1], log_dat[b+1]}), 32'h01280);
    n = 0;
    while (!INIT_DONE && n < 600) begin @(negedge CLK); n++; end
    chk("reinit_done", 32'(INIT_DONE), 32'd1);
    chk("reinit_err",  32'(ERR_FLAG), 32'd0);
    cycles(2);
`else
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    chk("idone_first_clk", 32'(INIT_DONE), 32'd1);
`endif

    // host read: latency and read-back
    host(1'b0, 1'b1, 8'h0A, 8'h00);
    chk("lat_n1", 32'(SCCB_REQ), 32'd0);
    @(negedge CLK);
    chk("lat_req", 32'(SCCB_REQ), 32'd1);
    chk("lat_cmd", 32'({SCCB_RW, SCCB_ADR}), 32'h10A);
    @(negedge CLK);
    chk("req_1cyc", 32'(SCCB_REQ), 32'd0);
    wait_rdv(30, seen);
    chk("rd_seen", 32'(seen), 32'd1);
    chk("rd_data", 32'(RD_DATA), 32'h76);
    @(negedge CLK);
    chk("rdv_pulse", 32'(RD_VALID), 32'd0);

    // WR and RD together: write wins, nothing dropped
    b = nreq;
    host(1'b1, 1'b1, 8'h20, 8'h11);
    chk("both_nodrop", 32'(HOST_DROP), 32'd0);
    wait_req(b + 1, 10, "both_req");
    chk("both_cmd", 32'({log_rw[b], log_adr[b], log_dat[b]}), 32'h02011);
    cycles(15);

    // slot held while busy; drop on full; capture in the REQ cycle
    SCCB_BUSY = 1'b1;
    b = nreq;
    host(1'b1, 1'b0, 8'h3A, 8'h04);
    cycles(3);
    chk("busy_noreq", 32'(SCCB_REQ), 32'd0);
    host(1'b1, 1'b0, 8'h55, 8'hAA);
    chk("full_drop", 32'(HOST_DROP), 32'd1);
    chk("full_keep", 32'({SCCB_ADR, SCCB_WDATA}), 32'h3A04);
    SCCB_BUSY = 1'b0; HOST_RD = 1'b1; HOST_ADR = 8'h0B;
    @(negedge CLK);
    HOST_RD = 1'b0;
    chk("reqcyc_nodrop", 32'(HOST_DROP), 32'd0);
    wait_req(b + 2, 60, "reqcyc_second");
    chk("slot_first",  32'({log_rw[b], log_adr[b], log_dat[b]}), 32'h03A04);
    chk("slot_second", 32'({log_rw[b+1], log_adr[b+1]}), 32'h10B);
    wait_rdv(30, seen);
    chk("slot_second_rd", 32'(seen), 32'd1);
    cycles(2);

    // timeout
    hang = 1'b1;
    b = nreq;
    host(1'b1, 1'b0, 8'h40, 8'hD0);
    wait_req(b + 1, 10, "tmo_req");
    chk("tmo_err_pre", 32'(ERR_FLAG), 32'd0);
    n = 0;
    while (!ERR_FLAG && n < 100) begin @(negedge CLK); n++; end
    chk("tmo_lat", 32'(n >= TMO && n <= TMO + 1), 32'd1);
    hang = 1'b0;
    cycles(2);
    host(1'b0, 1'b1, 8'h0A, 8'h00);
    wait_rdv(30, seen);
    chk("after_tmo_rd", 32'(seen), 32'd1);
    chk("err_sticky", 32'(ERR_FLAG), 32'd1);
    cycles(2);

    // NACKed read gives no RD_VALID
    nack_at = nreq;
    host(1'b0, 1'b1, 8'h0C, 8'h00);
    wait_rdv(30, seen);
    chk("nack_no_rdv", 32'(seen), 32'd0);
    chk("nack_rd_keep", 32'(RD_DATA), 32'h76);
    nack_at = -1;

    // host soft-reset write delays the next command
    b = nreq;
    host(1'b1, 1'b0, 8'h12, 8'h80);
    cycles(3);
    host(1'b0, 1'b1, 8'h0A, 8'h00);
    wait_req(b + 2, 100, "hswrst_req");
    chk("hswrst_gap", 32'(log_cyc[b+1] - log_cyc[b] >= SWRST + 10), 32'd1);
    wait_rdv(30, seen);
    cycles(2);

    // reset during a host transfer
    hang = 1'b1;
    b = nreq;
    host(1'b1, 1'b0, 8'h3E, 8'h00);
    wait_req(b + 1, 10, "hrst_req");
    RESET = 1'b1;
    #1;
    chk("hrst_req0",  32'(SCCB_REQ), 32'd0);
    chk("hrst_err",   32'(ERR_FLAG), 32'd0);
    chk("hrst_idone", 32'(INIT_DONE), 32'd0);
    chk("hrst_cmd",   32'({SCCB_RW, SCCB_ADR, SCCB_WDATA}), 32'd0);
    chk("hrst_rdata", 32'(RD_DATA), 32'd0);
    hang = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
`ifndef OV7670_INIT_ROM_EN
    chk("hrst_idone_back", 32'(INIT_DONE), 32'd1);
`else
    chk("hrst_pwrup", 32'(INIT_DONE), 32'd0);
`endif
    cycles(5);
    chk("hrst_slot_empty", 32'(nreq), 32'(b + 1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
